issue_hazard_ctrl: RTL and testbench

Dual-issue interlock that sits between the ID stage and EX issue, paired with the EX-stage forwarding network. Forwarding covers only ALU results from MEM and final results from WB. This block stalls any consumer whose producer's value cannot be forwarded, which covers load, mul, div and csr results still in EX. It also splits a pair when slot B reads slot A's destination, and keeps a saturating counter of hazard stall cycles for performance profiling.

---
 rtl/issue_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_issue_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl: dual-issue ID->EX interlock for unforwardable EX results and intra-pair RAW splits
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   flush, pipe_stall         pipeline flush (wins) and downstream freeze
//   ID_valid_*, ID_rf_*       slot A/B decode info: sources, destinations, write enables
//   ID_long_*                 result only forwardable from WB (load/mul/div/csr)
//   ID_issue_a/b, ID_stall    combinational issue decisions and ID hold
//   ID_split                  slot A of the held pair has already issued
//   perf_hazard_cnt           saturating count of hazard stall cycles
module issue_hazard_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        pipe_stall,
    input  logic        ID_valid_a,
    input  logic        ID_valid_b,
    input  logic [4:0]  ID_rf_raddr_a1,
    input  logic [4:0]  ID_rf_raddr_a2,
    input  logic [4:0]  ID_rf_raddr_b1,
    input  logic [4:0]  ID_rf_raddr_b2,
    input  logic        ID_rf_re_a1,
    input  logic        ID_rf_re_a2,
    input  logic        ID_rf_re_b1,
    input  logic        ID_rf_re_b2,
    input  logic [4:0]  ID_rf_waddr_a,
    input  logic [4:0]  ID_rf_waddr_b,
    input  logic        ID_rf_we_a,
    input  logic        ID_rf_we_b,
    input  logic        ID_long_a,
    input  logic        ID_long_b,
    output logic        ID_issue_a,
    output logic        ID_issue_b,
    output logic        ID_stall,
    output logic        ID_split,
    output logic [31:0] perf_hazard_cnt
);
    typedef enum logic {PAIR, B_ONLY} state_t;
    state_t      state;
    logic        ta_v, tb_v;
    logic [4:0]  ta_w, tb_w;
    logic [31:0] hazard_cnt;
    logic        haz_a, haz_b, dep_ba, hazard_cycle;

    // A source is blocked only by a long-latency producer still sitting in EX.
    function automatic logic src_haz(input logic re, input logic [4:0] r,
                                     input logic av, input logic [4:0] aw,
                                     input logic bv, input logic [4:0] bw);
        return re & (r != 5'd0) & ((av & (aw == r)) | (bv & (bw == r)));
    endfunction

    assign haz_a = ID_valid_a & (src_haz(ID_rf_re_a1, ID_rf_raddr_a1, ta_v, ta_w, tb_v, tb_w) |
                                 src_haz(ID_rf_re_a2, ID_rf_raddr_a2, ta_v, ta_w, tb_v, tb_w));
    assign haz_b = ID_valid_b & (src_haz(ID_rf_re_b1, ID_rf_raddr_b1, ta_v, ta_w, tb_v, tb_w) |
                                 src_haz(ID_rf_re_b2, ID_rf_raddr_b2, ta_v, ta_w, tb_v, tb_w));
    assign dep_ba = ID_valid_b & ID_rf_we_a &
                    ((ID_rf_re_b1 & (ID_rf_raddr_b1 == ID_rf_waddr_a) & (ID_rf_raddr_b1 != 5'd0)) |
                     (ID_rf_re_b2 & (ID_rf_raddr_b2 == ID_rf_waddr_a) & (ID_rf_raddr_b2 != 5'd0)));
    assign ID_split = (state == B_ONLY);
    assign perf_hazard_cnt = hazard_cnt;

    always_comb begin
        ID_issue_a = 1'b0;
        ID_issue_b = 1'b0;
        ID_stall = 1'b0;
        hazard_cycle = 1'b0;
        if (flush) begin
            ID_stall = 1'b0;
        end else if (pipe_stall) begin
            ID_stall = 1'b1;
        end else if (state == B_ONLY) begin
            // A already issued; it is now covered by T_a, so depBA no longer applies.
            ID_issue_b = ID_valid_b & ~haz_b;
            ID_stall = haz_b;
            hazard_cycle = haz_b;
        end else if (ID_valid_a) begin
            ID_issue_a = ~haz_a;
            ID_issue_b = ~haz_a & ~haz_b & ~dep_ba & ID_valid_b;
            ID_stall = haz_a | haz_b | dep_ba;
            hazard_cycle = ID_stall;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= PAIR;
            ta_v <= 1'b0;
            tb_v <= 1'b0;
            ta_w <= 5'd0;
            tb_w <= 5'd0;
            hazard_cnt <= 32'd0;
        end else if (flush) begin
            state <= PAIR;
            ta_v <= 1'b0;
            tb_v <= 1'b0;
        end else if (!pipe_stall) begin
            // Stay/enter B_ONLY when holding the pair after A went (split) or while B waits.
            state <= (ID_stall & (ID_issue_a | (state == B_ONLY))) ? B_ONLY : PAIR;
            ta_v <= ID_issue_a & ID_rf_we_a & ID_long_a;
            tb_v <= ID_issue_b & ID_rf_we_b & ID_long_b;
            ta_w <= ID_rf_waddr_a;
            tb_w <= ID_rf_waddr_b;
            if (hazard_cycle && hazard_cnt != 32'hFFFF_FFFF)
                hazard_cnt <= hazard_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// tb_issue_hazard_ctrl: table-driven scoreboard bench for issue_hazard_ctrl
module tb_issue_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rstn, flush, pipe_stall;
    logic        ID_valid_a, ID_valid_b;
    logic [4:0]  ID_rf_raddr_a1, ID_rf_raddr_a2, ID_rf_raddr_b1, ID_rf_raddr_b2;
    logic        ID_rf_re_a1, ID_rf_re_a2, ID_rf_re_b1, ID_rf_re_b2;
    logic [4:0]  ID_rf_waddr_a, ID_rf_waddr_b;
    logic        ID_rf_we_a, ID_rf_we_b, ID_long_a, ID_long_b;
    logic        ID_issue_a, ID_issue_b, ID_stall, ID_split;
    logic [31:0] perf_hazard_cnt;

    typedef struct packed {
        logic       v;
        logic [4:0] r1, r2;
        logic [1:0] re;
        logic [4:0] rd;
        logic       we, lg;
    } slot_t;

    typedef struct packed {
        logic        fl, ps;
        slot_t       a, b;
        logic        ia, ib, st, sp;
        logic [31:0] cnt;
    } vec_t;

    typedef logic [35:0] obs_t;

    vec_t tbl[$];
    obs_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    issue_hazard_ctrl dut (
        .clk(clk), .rstn(rstn), .flush(flush), .pipe_stall(pipe_stall),
        .ID_valid_a(ID_valid_a), .ID_valid_b(ID_valid_b),
        .ID_rf_raddr_a1(ID_rf_raddr_a1), .ID_rf_raddr_a2(ID_rf_raddr_a2),
        .ID_rf_raddr_b1(ID_rf_raddr_b1), .ID_rf_raddr_b2(ID_rf_raddr_b2),
        .ID_rf_re_a1(ID_rf_re_a1), .ID_rf_re_a2(ID_rf_re_a2),
        .ID_rf_re_b1(ID_rf_re_b1), .ID_rf_re_b2(ID_rf_re_b2),
        .ID_rf_waddr_a(ID_rf_waddr_a), .ID_rf_waddr_b(ID_rf_waddr_b),
        .ID_rf_we_a(ID_rf_we_a), .ID_rf_we_b(ID_rf_we_b),
        .ID_long_a(ID_long_a), .ID_long_b(ID_long_b),
        .ID_issue_a(ID_issue_a), .ID_issue_b(ID_issue_b),
        .ID_stall(ID_stall), .ID_split(ID_split),
        .perf_hazard_cnt(perf_hazard_cnt)
    );

    always #5 clk = ~clk;

    function automatic slot_t s(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [1:0] re, input logic [4:0] rd,
                                input logic we, input logic lg);
        return '{v: v, r1: r1, r2: r2, re: re, rd: rd, we: we, lg: lg};
    endfunction

    function automatic vec_t mk(input logic fl, input logic ps, input slot_t a, input slot_t b,
                                input logic ia, input logic ib, input logic st, input logic sp,
                                input logic [31:0] cnt);
        return '{fl: fl, ps: ps, a: a, b: b, ia: ia, ib: ib, st: st, sp: sp, cnt: cnt};
    endfunction

    task automatic drive(input vec_t t);
        flush = t.fl;
        pipe_stall = t.ps;
        ID_valid_a = t.a.v;
        ID_rf_raddr_a1 = t.a.r1;
        ID_rf_raddr_a2 = t.a.r2;
        ID_rf_re_a1 = t.a.re[0];
        ID_rf_re_a2 = t.a.re[1];
        ID_rf_waddr_a = t.a.rd;
        ID_rf_we_a = t.a.we;
        ID_long_a = t.a.lg;
        ID_valid_b = t.b.v;
        ID_rf_raddr_b1 = t.b.r1;
        ID_rf_raddr_b2 = t.b.r2;
        ID_rf_re_b1 = t.b.re[0];
        ID_rf_re_b2 = t.b.re[1];
        ID_rf_waddr_b = t.b.rd;
        ID_rf_we_b = t.b.we;
        ID_long_b = t.b.lg;
        exp_q.push_back({t.ia, t.ib, t.st, t.sp, t.cnt});
    endtask

    task automatic check(input string name);
        obs_t e, o;
        e = exp_q.pop_front();
        o = {ID_issue_a, ID_issue_b, ID_stall, ID_split, perf_hazard_cnt};
        total++;
        if (o === e) passed++;
        else $display("FAIL %s: got ia/ib/st/sp=%b%b%b%b cnt=%h, want %b%b%b%b cnt=%h",
                      name, o[35], o[34], o[33], o[32], o[31:0], e[35], e[34], e[33], e[32], e[31:0]);
    endtask

    task automatic apply(input vec_t t, input string name);
        @(negedge clk);
        drive(t);
        #1 check(name);
    endtask

    slot_t nop, ld5, use5, add3, rd3, mul7, rd7b, ld4, r0r9a, r0r9b, add4, use4a, use4b;
    slot_t waw, ld15, mul16, plain17, rd16, ld20, use20, ld3, use3;

    initial begin
        nop     = s(0, 0, 0, 2'b00, 0, 0, 0);
        ld5     = s(1, 0, 0, 2'b00, 5, 1, 1);
        use5    = s(1, 5, 0, 2'b01, 6, 1, 0);
        add3    = s(1, 0, 0, 2'b00, 3, 1, 0);
        rd3     = s(1, 3, 0, 2'b01, 8, 1, 0);
        mul7    = s(1, 0, 0, 2'b00, 7, 1, 1);
        rd7b    = s(1, 1, 7, 2'b10, 9, 1, 0);
        ld4     = s(1, 0, 0, 2'b00, 4, 1, 1);
        r0r9a   = s(1, 0, 9, 2'b11, 10, 1, 0);
        r0r9b   = s(1, 0, 9, 2'b11, 11, 1, 0);
        add4    = s(1, 0, 0, 2'b00, 4, 1, 0);
        use4a   = s(1, 4, 0, 2'b01, 12, 1, 0);
        use4b   = s(1, 0, 4, 2'b10, 2, 1, 0);
        waw     = s(1, 0, 0, 2'b00, 13, 1, 0);
        ld15    = s(1, 0, 0, 2'b00, 15, 1, 1);
        mul16   = s(1, 0, 0, 2'b00, 16, 1, 1);
        plain17 = s(1, 1, 0, 2'b01, 17, 1, 0);
        rd16    = s(1, 16, 0, 2'b01, 18, 1, 0);
        ld20    = s(1, 0, 0, 2'b00, 20, 1, 1);
        use20   = s(1, 20, 0, 2'b01, 21, 1, 0);
        ld3     = s(1, 0, 0, 2'b00, 3, 1, 1);
        use3    = s(1, 3, 0, 2'b01, 0, 0, 0);

        // Consecutive cycles; expected values are the pre-edge outputs of each cycle.
        tbl.push_back(mk(0, 0, nop,   nop,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, ld5,   nop,   1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, use5,  nop,   0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, use5,  nop,   1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, add3,  rd3,   1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, add3,  rd3,   0, 1, 0, 1, 2));
        tbl.push_back(mk(0, 0, mul7,  rd7b,  1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, mul7,  rd7b,  0, 0, 1, 1, 3));
        tbl.push_back(mk(0, 0, mul7,  rd7b,  0, 1, 0, 1, 4));
        tbl.push_back(mk(0, 0, ld4,   nop,   1, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, r0r9a, r0r9b, 1, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0, add4,  nop,   1, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, use4a, use4b, 1, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0, waw,   waw,   1, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0, ld15,  mul16, 1, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0, plain17, rd16, 1, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, plain17, rd16, 0, 1, 0, 1, 5));
        tbl.push_back(mk(0, 0, ld20,  nop,   1, 0, 0, 0, 5));
        tbl.push_back(mk(0, 1, use20, nop,   0, 0, 1, 0, 5));
        tbl.push_back(mk(0, 1, use20, nop,   0, 0, 1, 0, 5));
        tbl.push_back(mk(0, 1, use20, nop,   0, 0, 1, 0, 5));
        tbl.push_back(mk(0, 0, use20, nop,   0, 0, 1, 0, 5));
        tbl.push_back(mk(0, 0, use20, nop,   1, 0, 0, 0, 6));
        tbl.push_back(mk(0, 0, ld3,   rd3,   1, 0, 1, 0, 6));
        tbl.push_back(mk(1, 0, ld3,   rd3,   0, 0, 0, 1, 7));
        tbl.push_back(mk(0, 0, use3,  nop,   1, 0, 0, 0, 7));
        tbl.push_back(mk(1, 0, add3,  rd3,   0, 0, 0, 0, 7));
        tbl.push_back(mk(0, 0, add3,  rd3,   1, 0, 1, 0, 7));

        rstn = 1'b0;
        drive(mk(0, 0, nop, nop, 0, 0, 0, 0, 0));
        #1 check("reset_state");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("row%0d", i));

        // Reset while in B_ONLY: pending B dropped, counter cleared immediately.
        @(negedge clk);
        rstn = 1'b0;
        drive(mk(0, 0, add3, rd3, 1, 0, 1, 0, 0));
        #1 check("reset_mid_split");
        #2;
        ID_valid_a = 1'b0;
        ID_valid_b = 1'b0;
        rstn = 1'b1;

        apply(mk(1, 1, add3, rd3, 0, 0, 0, 0, 0), "flush_over_stall");

        // Preload the counter one below saturation while frozen.
        @(negedge clk);
        drive(mk(0, 1, nop, nop, 0, 0, 1, 0, 0));
        force dut.hazard_cnt = 32'hFFFF_FFFE;
        #1 release dut.hazard_cnt;
        void'(exp_q.pop_front());
        apply(mk(0, 0, mul7, rd7b, 1, 0, 1, 0, 32'hFFFF_FFFE), "sat_split");
        apply(mk(0, 0, mul7, rd7b, 0, 0, 1, 1, 32'hFFFF_FFFF), "sat_reach");
        apply(mk(0, 0, mul7, rd7b, 0, 1, 0, 1, 32'hFFFF_FFFF), "sat_hold");
        apply(mk(0, 0, nop,  nop,  0, 0, 0, 0, 32'hFFFF_FFFF), "sat_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
